// File: rtl/conv_window_3x3_dual_if.sv
// ---------------------------------------------------------------------------
// conv_window_3x3_dual_if
//   Bundles the streaming pixel/tap inputs, the frame-size configuration and
//   the dual-lane 3x3 window outputs of conv_window_3x3_dual.
//
//   master : upstream/test side; drives configuration, pixels and row taps,
//            receives the windows and the frame markers.
//   slave  : the window builder itself.
//
//   img_w_ctrl/img_h_ctrl : frame width/height, sampled on cfg_load
//   cfg_load              : synchronous reconfigure + restart pulse
//   pix_valid             : accept strobe for the current column of all taps
//   pix_in_x/row1_x/row2_x: current row, one row above, two rows above
//   win_x                 : 3x3 window, element (r,c) at [DATA_W*(3r+c) +: DATA_W]
//   win_valid/win_last    : fresh interior window / last window of the frame
//   frame_done            : one-cycle pulse at frame completion
// ---------------------------------------------------------------------------
interface conv_window_3x3_dual_if #(
    parameter int DATA_W = 8
);
    logic [8:0]          img_w_ctrl;
    logic [8:0]          img_h_ctrl;
    logic                cfg_load;
    logic                pix_valid;
    logic [DATA_W-1:0]   pix_in_0;
    logic [DATA_W-1:0]   pix_in_1;
    logic [DATA_W-1:0]   row1_0;
    logic [DATA_W-1:0]   row1_1;
    logic [DATA_W-1:0]   row2_0;
    logic [DATA_W-1:0]   row2_1;
    logic [9*DATA_W-1:0] win_0;
    logic [9*DATA_W-1:0] win_1;
    logic                win_valid;
    logic                win_last;
    logic                frame_done;

    modport master (
        output img_w_ctrl, img_h_ctrl, cfg_load, pix_valid,
        output pix_in_0, pix_in_1, row1_0, row1_1, row2_0, row2_1,
        input  win_0, win_1, win_valid, win_last, frame_done
    );

    modport slave (
        input  img_w_ctrl, img_h_ctrl, cfg_load, pix_valid,
        input  pix_in_0, pix_in_1, row1_0, row1_1, row2_0, row2_1,
        output win_0, win_1, win_valid, win_last, frame_done
    );
endinterface

// File: rtl/conv_window_3x3_dual.sv
// ---------------------------------------------------------------------------
// conv_window_3x3_dual
//   Builds a 3x3 sliding window per lane from the live pixel and the one-row /
//   two-row delayed taps of the row-buffer chain. Column/row counters track the
//   position inside a runtime-configurable frame; only fully interior windows
//   (col>=2, row>=2) are flagged, i.e. valid-mode convolution without padding.
//
//   Ports
//     clk  : system clock
//     rstn : asynchronous active-low reset
//     bus  : conv_window_3x3_dual_if.slave (configuration, pixel/tap stream,
//            window outputs and frame markers)
// ---------------------------------------------------------------------------
module conv_window_3x3_dual #(
    parameter int DATA_W = 8,
    parameter int DEF_W  = 320,
    parameter int DEF_H  = 320
) (
    input  logic                         clk,
    input  logic                         rstn,
    conv_window_3x3_dual_if.slave        bus
);

    localparam int LANES = 2;

    typedef enum logic {
        ST_FILL = 1'b0,   // rows 0 and 1: window does not yet span three rows
        ST_RUN  = 1'b1    // rows 2..H-1: interior windows possible
    } state_e;

    // Sizes below 3 cannot hold a single interior window; treat them as 3.
    function automatic logic [8:0] clamp3(input logic [8:0] v);
        return (v < 9'd3) ? 9'd3 : v;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e            state_q;
    logic [8:0]        w_q, w_d;
    logic [8:0]        h_q, h_d;
    logic [8:0]        col_q, col_d;
    logic [8:0]        row_q, row_d;
    logic              win_valid_q, win_valid_d;
    logic              win_last_q, win_last_d;
    logic              frame_done_q, frame_done_d;

    // win_q[lane][r][c]: r=0 top (two rows above), c=0 oldest column
    logic [DATA_W-1:0] win_q [LANES][3][3];
    logic [DATA_W-1:0] win_d [LANES][3][3];
    logic [DATA_W-1:0] col_in [LANES][3];

    logic              accept;
    logic              col_last;
    logic              row_last;
    logic              interior;

    // cfg_load wins over pix_valid: the coinciding pixel is dropped.
    assign accept   = bus.pix_valid & ~bus.cfg_load;
    assign col_last = (col_q == w_q - 9'd1);
    assign row_last = (row_q == h_q - 9'd1);
    // ST_RUN holds exactly while row_q >= 2, so it stands in for the row test.
    assign interior = (state_q == ST_RUN) && (col_q >= 9'd2);

    // Incoming column per lane, top to bottom.
    always_comb begin
        col_in[0][0] = bus.row2_0;
        col_in[0][1] = bus.row1_0;
        col_in[0][2] = bus.pix_in_0;
        col_in[1][0] = bus.row2_1;
        col_in[1][1] = bus.row1_1;
        col_in[1][2] = bus.pix_in_1;
    end

    // -----------------------------------------------------------------------
    // Next-state logic for counters, configuration, window and flags
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_d          = w_q;
        h_d          = h_q;
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        win_last_d   = 1'b0;
        frame_done_d = 1'b0;

        if (bus.cfg_load) begin
            // Restart: new geometry, counters to (0,0); window contents kept.
            w_d   = clamp3(bus.img_w_ctrl);
            h_d   = clamp3(bus.img_h_ctrl);
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                for (int r = 0; r < 3; r++) begin
                    win_d[l][r][0] = win_q[l][r][1];
                    win_d[l][r][1] = win_q[l][r][2];
                    win_d[l][r][2] = col_in[l][r];
                end
            end

            if (col_last) begin
                col_d = '0;
                row_d = row_last ? 9'd0 : row_q + 9'd1;
            end else begin
                col_d = col_q + 9'd1;
            end

            // Flags are judged on the pre-increment position of this pixel.
            // With W,H >= 3 the frame's final pixel is always interior.
            win_valid_d  = interior;
            win_last_d   = interior & col_last & row_last;
            frame_done_d = col_last & row_last;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_q          <= 9'(DEF_W);
            h_q          <= 9'(DEF_H);
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            // NOTE: the window array is small and its reset value is visible
            // on win_* right after reset, so it is cleared like any register.
            for (int l = 0; l < LANES; l++) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        win_q[l][r][c] <= '0;
                    end
                end
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            w_q          <= w_d;
            h_q          <= h_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            win_last_q   <= win_last_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    // -----------------------------------------------------------------------
    // Row-phase FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_FILL;
        end else if (bus.cfg_load) begin
            state_q <= ST_FILL;
        end else if (accept) begin
            case (state_q)
                ST_FILL: if (col_last && (row_q == 9'd1)) state_q <= ST_RUN;
                ST_RUN:  if (col_last && row_last)        state_q <= ST_FILL;
                default:                                  state_q <= ST_FILL;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: straight from the registers
    // -----------------------------------------------------------------------
    logic [9*DATA_W-1:0] win0_flat;
    logic [9*DATA_W-1:0] win1_flat;

    always_comb begin
        win0_flat = '0;
        win1_flat = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win0_flat[DATA_W*(3*r+c) +: DATA_W] = win_q[0][r][c];
                win1_flat[DATA_W*(3*r+c) +: DATA_W] = win_q[1][r][c];
            end
        end
    end

    assign bus.win_0      = win0_flat;
    assign bus.win_1      = win1_flat;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_last   = win_last_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_3x3_dual.sv
// ---------------------------------------------------------------------------
// tb_conv_window_3x3_dual
//   Directed stimulus for conv_window_3x3_dual. Pixel value at (row,col) is
//   (row<<4)|col on lane 0 and its complement on lane 1; the row taps are the
//   same image one and two rows up. Each accepted interior pixel pushes its
//   expected window into a queue; a negedge monitor pops and compares
//   whenever win_valid is seen, and checks that the window holds otherwise.
// ---------------------------------------------------------------------------
module tb_conv_window_3x3_dual;

    localparam int DATA_W = 8;
    localparam int WW     = 9 * DATA_W;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    conv_window_3x3_dual_if #(.DATA_W(DATA_W)) bus ();

    conv_window_3x3_dual #(
        .DATA_W (DATA_W),
        .DEF_W  (320),
        .DEF_H  (320)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [WW-1:0] w0;
        logic [WW-1:0] w1;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            total = 0;
    int            bad   = 0;
    int            win_seen  = 0;
    int            done_seen = 0;
    logic          first_armed = 1'b0;
    logic [WW-1:0] first_w0 = '0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pv(input int r, input int c);
        return 8'((r << 4) | c);
    endfunction

    task automatic drive_pix(input int r, input int c);
        bus.pix_in_0 = pv(r, c);
        bus.pix_in_1 = ~pv(r, c);
        bus.row1_0   = (r >= 1) ? pv(r - 1, c) : 8'h00;
        bus.row1_1   = ~bus.row1_0;
        bus.row2_0   = (r >= 2) ? pv(r - 2, c) : 8'h00;
        bus.row2_1   = ~bus.row2_0;
    endtask

    // Present pixel (r,c) of a w x h frame, optionally preceded by idle cycles.
    task automatic send_pix(input int r, input int c, input int w, input int h, input int gap_pct);
        exp_t e;
        @(posedge clk); #1;
        bus.cfg_load = 1'b0;
        while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            bus.pix_valid = 1'b0;
            @(posedge clk); #1;
        end
        drive_pix(r, c);
        bus.pix_valid = 1'b1;
        if (r >= 2 && c >= 2) begin
            e.w0 = '0;
            for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 3; cc++)
                    e.w0[DATA_W*(3*rr+cc) +: DATA_W] = pv(r - 2 + rr, c - 2 + cc);
            e.w1   = ~e.w0;
            e.last = (r == h - 1) && (c == w - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send_frame(input int w, input int h, input int npix, input int gap_pct);
        for (int i = 0; i < npix; i++) send_pix(i / w, i % w, w, h, gap_pct);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        bus.cfg_load  = 1'b0;
    endtask

    task automatic cfg(input int w, input int h);
        @(posedge clk); #1;
        bus.pix_valid  = 1'b0;
        bus.cfg_load   = 1'b1;
        bus.img_w_ctrl = 9'(w);
        bus.img_h_ctrl = 9'(h);
    endtask

    // Let the last accepted pixel reach the monitor; bounded wait.
    task automatic drain(input string name);
        idle();
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
        @(negedge clk); #1;
        check({name, "_drain"}, 128'(sb.size()), 128'd0);
        sb.delete();
    endtask

    task automatic expect_counts(input string name, input int w_base, input int d_base,
                                 input int exp_w, input int exp_d);
        check({name, "_windows"},    128'(win_seen - w_base),  128'(exp_w));
        check({name, "_frame_done"}, 128'(done_seen - d_base), 128'(exp_d));
    endtask

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    logic          prev_acc  = 1'b0;
    logic          prev_rstn = 1'b0;
    logic [WW-1:0] prev_w0   = '0;
    logic [WW-1:0] prev_w1   = '0;

    always @(negedge clk) begin
        if (rstn && prev_rstn) begin
            if (!prev_acc) begin
                check("hold_valid", 128'(bus.win_valid), 128'd0);
                check("hold_win0",  128'(bus.win_0), 128'(prev_w0));
                check("hold_win1",  128'(bus.win_1), 128'(prev_w1));
            end
            if (bus.win_valid) begin
                win_seen++;
                if (bus.frame_done) done_seen++;
                if (first_armed) begin
                    first_w0    = bus.win_0;
                    first_armed = 1'b0;
                end
                check("sb_has_entry", 128'(sb.size() != 0), 128'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("win0",       128'(bus.win_0),      128'(mon_e.w0));
                    check("win1",       128'(bus.win_1),      128'(mon_e.w1));
                    check("win_last",   128'(bus.win_last),   128'(mon_e.last));
                    check("frame_done", 128'(bus.frame_done), 128'(mon_e.last));
                end
            end else begin
                check("idle_frame_done", 128'(bus.frame_done), 128'd0);
            end
        end
        prev_acc  = bus.pix_valid & ~bus.cfg_load;
        prev_rstn = rstn;
        prev_w0   = bus.win_0;
        prev_w1   = bus.win_1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int wb;
        int db;
        rstn           = 1'b0;
        bus.cfg_load   = 1'b0;
        bus.pix_valid  = 1'b0;
        bus.img_w_ctrl = '0;
        bus.img_h_ctrl = '0;
        drive_pix(0, 0);

        // Reset state
        #2;
        check("rst_win_valid",  128'(bus.win_valid),  128'd0);
        check("rst_win_last",   128'(bus.win_last),   128'd0);
        check("rst_frame_done", 128'(bus.frame_done), 128'd0);
        check("rst_win0",       128'(bus.win_0),      128'd0);
        check("rst_win1",       128'(bus.win_1),      128'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // 5x4 frame, no gaps; first window checked by hand
        wb = win_seen; db = done_seen;
        first_armed = 1'b1;
        cfg(5, 4);
        send_frame(5, 4, 20, 0);
        drain("f5x4");
        expect_counts("f5x4", wb, db, 6, 1);
        check("first_w0_00", 128'(first_w0[DATA_W*0 +: DATA_W]), 128'h00);
        check("first_w0_11", 128'(first_w0[DATA_W*4 +: DATA_W]), 128'h11);
        check("first_w0_22", 128'(first_w0[DATA_W*8 +: DATA_W]), 128'h22);
        check("first_w0_02", 128'(first_w0[DATA_W*2 +: DATA_W]), 128'h02);
        check("first_w0_20", 128'(first_w0[DATA_W*6 +: DATA_W]), 128'h20);

        // Same frame with ~30% idle cycles
        wb = win_seen; db = done_seen;
        send_frame(5, 4, 20, 30);
        drain("gaps");
        expect_counts("gaps", wb, db, 6, 1);

        // Two consecutive frames
        wb = win_seen; db = done_seen;
        send_frame(5, 4, 20, 0);
        send_frame(5, 4, 20, 0);
        drain("two_frames");
        expect_counts("two_frames", wb, db, 12, 2);

        // cfg_load mid-frame with a coinciding pixel at (col 3, row 2)
        wb = win_seen; db = done_seen;
        cfg(5, 4);
        send_frame(5, 4, 13, 0);
        @(posedge clk); #1;
        drive_pix(2, 3);
        bus.pix_valid  = 1'b1;
        bus.cfg_load   = 1'b1;
        bus.img_w_ctrl = 9'd10;
        bus.img_h_ctrl = 9'd10;
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        bus.cfg_load  = 1'b0;
        @(negedge clk); #1;
        check("cfg_drop_valid", 128'(bus.win_valid), 128'd0);
        check("cfg_drop_done",  128'(bus.frame_done), 128'd0);
        send_frame(10, 10, 100, 0);
        drain("cfg_mid");
        expect_counts("cfg_mid", wb, db, 1 + 64, 1);

        // Clamp: 2x2 behaves as 3x3
        wb = win_seen; db = done_seen;
        cfg(2, 2);
        send_frame(3, 3, 9, 0);
        drain("clamp");
        expect_counts("clamp", wb, db, 1, 1);

        // Reset mid-frame while a window is being presented
        cfg(10, 10);
        send_frame(10, 10, 25, 0);
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check("midrst_win_valid",  128'(bus.win_valid),  128'd0);
        check("midrst_win_last",   128'(bus.win_last),   128'd0);
        check("midrst_frame_done", 128'(bus.frame_done), 128'd0);
        check("midrst_win0",       128'(bus.win_0),      128'd0);
        check("midrst_win1",       128'(bus.win_1),      128'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Default 320-wide geometry: rows 0..2 plus six pixels of row 3
        wb = win_seen; db = done_seen;
        send_frame(320, 320, 3 * 320 + 6, 0);
        drain("default_w");
        expect_counts("default_w", wb, db, 318 + 4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_window_3x3_dual.md
# conv_window_3x3_dual

Consumes the dual-lane 8-bit pixel stream together with the one-row and two-row delayed taps produced by the row-buffer chain, and assembles a 3x3 sliding window per lane for the convolution MAC array. It tracks column and row position against a runtime-configurable frame size and flags only fully interior windows, which gives valid-mode convolution with no padding. It also marks the last window of each frame. It sits directly downstream of the row buffers and upstream of the conv PE.

## Interface
- DATA_W, 8, bits per pixel per lane
- DEF_W, 320, frame width loaded at reset
- DEF_H, 320, frame height loaded at reset
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- img_w_ctrl  in  9  frame width (320/80/40/20/10); latched on cfg_load
- img_h_ctrl  in  9  frame height; latched on cfg_load
- cfg_load  in  1  synchronous reconfigure and restart pulse
- pix_valid  in  1  pixel accept strobe for the current column of all taps
- pix_in_0, pix_in_1  in  DATA_W  current-row pixel, lanes 0 and 1
- row1_0, row1_1  in  DATA_W  pixel one row above, aligned with pix_in
- row2_0, row2_1  in  DATA_W  pixel two rows above, aligned with pix_in
- win_0, win_1  out  9*DATA_W  3x3 window; element (r,c) at bits [DATA_W*(3r+c) +: DATA_W]; r=0 is the top row (row2), c=0 is the leftmost (oldest) column
- win_valid  out  1  window is interior and fresh
- win_last  out  1  qualifies win_valid: last window of frame
- frame_done  out  1  one-cycle pulse at frame completion

## Operation
- Storage: per lane, three 3-stage column shift registers (rows r0/r1/r2 fed by row2/row1/pix_in). These registers drive win_* directly.
- Shifting happens only on an accepted pixel (pix_valid=1 and cfg_load=0):
  - new column enters c=2; c=2 moves to c=1; c=1 moves to c=0.
  - With no accepted pixel, the window holds.
- Counters: col_cnt runs 0..W-1, then wraps to 0 and increments row_cnt. row_cnt runs 0..H-1, then wraps to 0 (next frame).
- FSM states and transitions:
  - FILL (row_cnt<2): go to RUN on acceptance of pixel (W-1, 1).
  - RUN: go to FILL on acceptance of pixel (W-1, H-1), i.e. frame end.
  - cfg_load forces FILL from any state.
- Interior test, evaluated on the accepted pixel's pre-increment (col_cnt, row_cnt): col>=2 and row>=2.
- Window count per frame is (W-2)*(H-2).
- Configuration clamp: W or H below 3 is latched as 3. Values are 9-bit unsigned and no other check is applied.
- cfg_load has priority over pix_valid in the same cycle; the coinciding pixel is dropped. It also:
  - latches W/H
  - zeroes both counters
  - clears win_valid, win_last and frame_done
  - leaves the window contents unchanged.
- Reset values: W=DEF_W, H=DEF_H, counters 0, state FILL, all window registers 0, win_valid/win_last/frame_done 0.
- Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).

## Timing
- Latency: a pixel accepted at edge k appears in c=2 after edge k. win_valid for that window is registered at the same edge, so it is high in cycle k+1.
- win_valid is a one-cycle pulse per accepted interior pixel. Back-to-back acceptance gives continuous win_valid across each interior column run.
- win_valid drops between rows: for the first two pixels of each row the window straddles the row boundary, and no window is flagged there.
- win_last and frame_done assert in the same cycle as win_valid for the pixel (W-1, H-1).
- pix_valid gaps of any length are legal and change nothing but timing.
- Throughput: 1 pixel per lane per cycle.

## Test plan
- **5x4 frame, no gaps.** Stimulus: cfg W=5 H=4; lane0 pixel=(row<<4)|col, lane1=~lane0; bench supplies row taps from a reference model. Required: exactly 6 win_valid pulses. First window, after pixel (2,2): win_0 (0,0)=0x00, (1,1)=0x11, (2,2)=0x22, and win_1 = ~win_0. win_last and frame_done appear only with window (4,3).
- **Random pix_valid gaps (30% idle), same frame.** Required: identical window sequence, and the window holds during gaps.
- **Two consecutive frames.** Required: 6 windows each; second frame's first window is again at (2,2); frame_done pulses twice.
- **cfg_load mid-frame with pix_valid=1 same cycle.** Start at pixel (3,2), set W=10 H=10. Required: the coinciding pixel is dropped and win_valid is 0 next cycle. A following 10x10 frame yields 64 windows.
- **Clamp.** cfg W=2 H=2. Required: behaves as 3x3 and gives 1 window at pixel (2,2) with win_last=1.
- **rstn asserted mid-frame.** Required: all outputs 0 immediately. After release, W=H=320 and a full frame yields 318*318 windows.
